// File: rtl/spi_rx_frontend.sv
// SPI mode-0 slave receiver front end.
// Synchronises nCS/SCK/MOSI into the clk domain, assembles MSB-first bytes,
// and hands them to the core through a small FIFO on a valid/ready stream.
// Valid/ready: a byte transfers on every clk edge where rx_valid & rx_ready;
// rx_data/rx_first hold stable while rx_valid & !rx_ready.
module spi_rx_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       nCS,
    input  logic       SCK,
    input  logic       MOSI,
    output logic [7:0] rx_data,
    output logic       rx_first,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_abort,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       cs_active
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        RECV      = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] ncs_sync, sck_sync, mosi_sync, sync_ok;
    logic                   sck_d;
    logic                   ncs_s, sck_s, mosi_s, sync_done, sck_rise;

    logic [6:0] shift;
    logic [2:0] bit_cnt;
    logic       first_flag;
    logic       wr_en, shift_en, abort_c;
    logic [7:0] wr_byte;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, push, pop;
    logic [8:0]    head;

    // Pin synchronisers; sync_ok marks when every stage holds a real pin sample
    // so the reset-loaded nCS=1 cannot be mistaken for an idle bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ncs_sync  <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            sync_ok   <= '0;
            sck_d     <= 1'b0;
        end else begin
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sync_ok   <= {sync_ok[SYNC_STAGES-2:0], 1'b1};
            sck_d     <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sync_done = sync_ok[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_d;
    assign wr_byte   = {shift, mosi_s};

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT_IDLE;
        else          state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            WAIT_IDLE: if (sync_done && ncs_s) state_next = IDLE;
            IDLE:      if (!ncs_s)             state_next = RECV;
            RECV:      if (ncs_s)              state_next = IDLE;
            default:                           state_next = WAIT_IDLE;
        endcase
    end

    // FSM outputs: an 8th edge still completes its byte even if nCS rose in that cycle
    always_comb begin
        wr_en     = 1'b0;
        shift_en  = 1'b0;
        abort_c   = 1'b0;
        cs_active = 1'b0;
        if (state == RECV) begin
            wr_en     = sck_rise && (bit_cnt == 3'd7);
            shift_en  = sck_rise && (!ncs_s || bit_cnt == 3'd7);
            abort_c   = ncs_s && (bit_cnt != 3'd0) && !wr_en;
            cs_active = !ncs_s;
        end
    end

    // Byte assembly: shift register, bit counter and frame-start flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift      <= '0;
            bit_cnt    <= '0;
            first_flag <= 1'b0;
            rx_abort   <= 1'b0;
        end else begin
            rx_abort <= abort_c;
            if (state != RECV) begin
                bit_cnt    <= '0;
                first_flag <= 1'b1;
            end else if (shift_en) begin
                shift   <= wr_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (wr_en) first_flag <= 1'b0;
            end
        end
    end

    assign full = (count == CW'(FIFO_DEPTH));
    assign pop  = rx_valid & rx_ready;
    assign push = wr_en & (!full | pop);

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {first_flag, wr_byte};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a new drop wins over a clear in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     overflow <= 1'b0;
        else if (wr_en && full && !pop)   overflow <= 1'b1;
        else if (ovf_clr)                 overflow <= 1'b0;
    end

    assign head     = mem[rd_ptr];
    assign rx_valid = (count != '0);
    assign rx_data  = rx_valid ? head[7:0] : 8'h00;
    assign rx_first = rx_valid & head[8];

endmodule
